// File: rtl/iter_alu_if.sv
// Issue/completion bus between the multicycle controller (master) and iter_alu (slave).
interface iter_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             div_zero;
  logic             illegal;

  modport master (output start, op, a, b,
                  input  busy, done, result, result_hi, div_zero, illegal);
  modport slave  (input  start, op, a, b,
                  output busy, done, result, result_hi, div_zero, illegal);
endinterface

// File: rtl/iter_alu.sv
// Sequential ALU: single-cycle logic/add/sub/compare, WIDTH-step shift-add multiply
// and restoring divide. All outputs are registered.
module iter_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset_n,
  iter_alu_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {IDLE, EXEC1, ITER, FIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;   // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             dz_q, dz_d, ill_q, ill_d;
  logic [WIDTH-1:0] res_q, res_d, reshi_q, reshi_d;

  // Compares on the issue operands; SLT uses the overflow-corrected sign of a-b.
  logic [WIDTH:0] sub_ext;
  logic           sub_ovf, slt, sltu;
  always_comb begin
    sub_ext = {1'b0, bus.a} - {1'b0, bus.b};
    sub_ovf = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (bus.a[WIDTH-1] ^ sub_ext[WIDTH-1]);
    slt     = sub_ext[WIDTH-1] ^ sub_ovf;
    sltu    = sub_ext[WIDTH];
  end

  // One shift-add / restore-subtract step.
  logic [PW-1:0]    acc_step;
  logic [WIDTH:0]   prem, pdiff;
  logic [WIDTH-1:0] rem_step, quo_step;
  always_comb begin
    acc_step = work_q[0] ? acc_q + mcand_q : acc_q;
    prem     = {rem_q, work_q[WIDTH-1]};
    pdiff    = prem - {1'b0, b_q};
    rem_step = pdiff[WIDTH] ? prem[WIDTH-1:0] : pdiff[WIDTH-1:0];
    quo_step = {work_q[WIDTH-2:0], ~pdiff[WIDTH]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    b_d      = b_q;
    work_d   = work_q;
    rem_d    = rem_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    ill_d    = ill_q;
    res_d    = res_q;
    reshi_d  = reshi_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d  = 1'b1;
          dz_d    = 1'b0;
          ill_d   = 1'b0;
          state_d = EXEC1;
          done_d  = 1'b1;
          reshi_d = '0;
          unique case (bus.op)
            OP_AND:  res_d = bus.a & bus.b;
            OP_OR:   res_d = bus.a | bus.b;
            OP_ADD:  res_d = bus.a + bus.b;
            OP_SUB:  res_d = sub_ext[WIDTH-1:0];
            OP_SLT:  res_d = WIDTH'(slt);
            OP_SLTU: res_d = WIDTH'(sltu);
            OP_MULU: begin
              done_d   = 1'b0;
              res_d    = res_q;
              reshi_d  = reshi_q;
              mcand_d  = PW'(bus.a);
              work_d   = bus.b;
              acc_d    = '0;
              is_div_d = 1'b0;
              cnt_d    = CNT_W'(WIDTH);
              state_d  = ITER;
            end
            OP_DIVU: begin
              if (bus.b == '0) begin
                res_d   = '1;
                reshi_d = bus.a;
                dz_d    = 1'b1;
              end else begin
                done_d   = 1'b0;
                res_d    = res_q;
                reshi_d  = reshi_q;
                rem_d    = '0;
                work_d   = bus.a;
                b_d      = bus.b;
                is_div_d = 1'b1;
                cnt_d    = CNT_W'(WIDTH);
                state_d  = ITER;
              end
            end
            default: begin
              res_d = '0;
              ill_d = 1'b1;
            end
          endcase
        end
      end
      ITER: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          rem_d  = rem_step;
          work_d = quo_step;
        end else begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          work_d  = work_q >> 1;
        end
        // Last step lands straight in the output registers so done shows in FIN.
        if (cnt_q == CNT_W'(1)) begin
          done_d  = 1'b1;
          state_d = FIN;
          res_d   = is_div_q ? quo_step : acc_step[WIDTH-1:0];
          reshi_d = is_div_q ? rem_step : acc_step[PW-1:WIDTH];
        end
      end
      EXEC1, FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      b_q      <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
      res_q    <= '0;
      reshi_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      b_q      <= b_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      ill_q    <= ill_d;
      res_q    <= res_d;
      reshi_q  <= reshi_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.result_hi = reshi_q;
  assign bus.div_zero  = dz_q;
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu at WIDTH=32 and WIDTH=8: directed literal checks plus a
// cycle-by-cycle comparison against an arithmetic reference model.
module tb_iter_alu;
  typedef struct {
    logic [63:0] r;
    logic [63:0] rh;
    logic        dz;
    logic        ill;
    int          s;
    int          d;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp32[$];
  exp_t exp8[$];
  exp_t last[2];
  int   busy_until[2];

  iter_alu_if #(.WIDTH(32)) b32 ();
  iter_alu_if #(.WIDTH(8))  b8 ();

  iter_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32));
  iter_alu #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(b8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, want);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: what the op must produce, and how many cycles after issue done appears.
  function automatic void model(input int w, input logic [3:0] op, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] r,
                                output logic [63:0] rh, output logic dz, output logic ill,
                                output int lat);
    logic [63:0] m, p;
    longint sa, sb;
    m  = mask(w);
    sa = longint'(a << (64 - w)) >>> (64 - w);
    sb = longint'(b << (64 - w)) >>> (64 - w);
    r = 0; rh = 0; dz = 0; ill = 0; lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = (a + b) & m;
      4'b0110: r = (a - b) & m;
      4'b0111: r = (sa < sb) ? 64'd1 : 64'd0;
      4'b0011: r = (a < b) ? 64'd1 : 64'd0;
      4'b1000: begin p = a * b; r = p & m; rh = (p >> w) & m; lat = w + 1; end
      4'b1001: begin
        if (b == 0) begin r = m; rh = a; dz = 1; end
        else begin r = a / b; rh = a % b; lat = w + 1; end
      end
      default: ill = 1;
    endcase
  endfunction

  function automatic void clear_model();
    exp32.delete();
    exp8.delete();
    busy_until[0] = -1;
    busy_until[1] = -1;
    last[0] = '{default: 0};
    last[1] = '{default: 0};
  endfunction

  task automatic drive(input int k, input logic st, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (k == 0) begin
      b32.start = st; b32.op = op; b32.a = a[31:0]; b32.b = b[31:0]; b8.start = 1'b0;
    end else begin
      b8.start = st; b8.op = op; b8.a = a[7:0]; b8.b = b[7:0]; b32.start = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    b32.start = 1'b0; b8.start = 1'b0;
    b32.a = $urandom; b32.b = $urandom; b8.a = 8'($urandom); b8.b = 8'($urandom);
  endtask

  // Present start for one cycle; the bench decides from its own busy window whether it is taken.
  task automatic issue(input int k, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, output int s, output bit acc);
    exp_t e;
    logic [63:0] r, rh;
    logic dz, ill;
    int w, lat;
    w = (k == 0) ? 32 : 8;
    @(posedge clk); #1;
    s = cyc;
    drive(k, 1'b1, op, a, b);
    acc = (s > busy_until[k]);
    if (acc) begin
      model(w, op, a & mask(w), b & mask(w), r, rh, dz, ill, lat);
      e.r = r; e.rh = rh; e.dz = dz; e.ill = ill; e.s = s; e.d = s + lat;
      busy_until[k] = e.d;
      if (k == 0) exp32.push_back(e); else exp8.push_back(e);
    end
  endtask

  task automatic await_done(input int k, input int s, output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (((k == 0) ? b32.done : b8.done) === 1'b1) begin
        lat = cyc - s;
        break;
      end
    end
  endtask

  task automatic check_cycle(input int k, input logic busy, input logic done,
                             input logic [63:0] r, input logic [63:0] rh,
                             input logic dz, input logic ill);
    exp_t  e;
    int    n;
    bit    inflight, due;
    string tag;
    tag = (k == 0) ? "w32" : "w8";
    n = (k == 0) ? exp32.size() : exp8.size();
    e = '{default: 0};
    if (n > 0) e = (k == 0) ? exp32[0] : exp8[0];
    inflight = (n > 0) && (cyc > e.s);
    due      = inflight && (cyc == e.d);
    chk({tag, ".busy"}, 64'(busy), 64'(inflight));
    chk({tag, ".done"}, 64'(done), 64'(due));
    if (due) begin
      chk({tag, ".result"}, r, e.r);
      chk({tag, ".result_hi"}, rh, e.rh);
      chk({tag, ".div_zero"}, 64'(dz), 64'(e.dz));
      chk({tag, ".illegal"}, 64'(ill), 64'(e.ill));
      last[k] = e;
      if (k == 0) void'(exp32.pop_front()); else void'(exp8.pop_front());
    end else if (inflight) begin
      chk({tag, ".flags_cleared"}, {62'd0, dz, ill}, 64'd0);
    end else begin
      chk({tag, ".hold_result"}, r, last[k].r);
      chk({tag, ".hold_result_hi"}, rh, last[k].rh);
      chk({tag, ".hold_flags"}, {62'd0, dz, ill}, {62'd0, last[k].dz, last[k].ill});
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check_cycle(0, b32.busy, b32.done, 64'(b32.result), 64'(b32.result_hi),
                  b32.div_zero, b32.illegal);
      check_cycle(1, b8.busy, b8.done, 64'(b8.result), 64'(b8.result_hi),
                  b8.div_zero, b8.illegal);
    end
  end

  task automatic random_run(input int k, input int nops);
    logic [3:0]  ops[10];
    logic [3:0]  op;
    logic [63:0] a, b, m;
    int          s;
    bit          acc;
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h3, 4'h8, 4'h9, 4'h8, 4'h9};
    m = mask((k == 0) ? 32 : 8);
    for (int i = 0; i < nops; i++) begin
      op = ($urandom_range(0, 11) < 10) ? ops[$urandom_range(0, 9)] : 4'($urandom);
      a = {$urandom, $urandom} & m;
      b = {$urandom, $urandom} & m;
      if ($urandom_range(0, 7) == 0) b = 0;
      if ($urandom_range(0, 5) == 0) a = a >> $urandom_range(0, 6);
      issue(k, op, a, b, s, acc);
      for (int j = 0; j < 80 && cyc <= busy_until[k]; j++) begin
        if ($urandom_range(0, 3) == 0)
          issue(k, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, s, acc);
        else
          idle();
      end
      if ($urandom_range(0, 1) == 0) idle();
    end
  endtask

  initial begin
    int s, s1, lat;
    bit acc;
    clear_model();
    b32.start = 1'b0; b32.op = '0; b32.a = '0; b32.b = '0;
    b8.start = 1'b0;  b8.op = '0;  b8.a = '0;  b8.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 64'(b32.busy), 64'd0);
    chk("reset.done", 64'(b32.done), 64'd0);
    chk("reset.result", 64'(b32.result), 64'd0);
    reset_n = 1'b1;
    repeat (3) idle();

    issue(0, 4'b0110, 64'd5, 64'd7, s, acc);
    await_done(0, s, lat);
    chk("sub.latency", 64'(lat), 64'd1);
    chk("sub.result", 64'(b32.result), 64'hFFFF_FFFE);
    chk("sub.result_hi", 64'(b32.result_hi), 64'd0);

    issue(0, 4'b0111, 64'h8000_0000, 64'd1, s, acc);
    await_done(0, s, lat);
    chk("slt.neg", 64'(b32.result), 64'd1);
    issue(0, 4'b0011, 64'h8000_0000, 64'd1, s, acc);
    await_done(0, s, lat);
    chk("sltu.big", 64'(b32.result), 64'd0);
    issue(0, 4'b0111, 64'h7FFF_FFFF, 64'hFFFF_FFFF, s, acc);
    await_done(0, s, lat);
    chk("slt.ovf", 64'(b32.result), 64'd0);

    issue(0, 4'b1000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, s, acc);
    issue(0, 4'b0010, 64'd1, 64'd1, s1, acc);
    issue(0, 4'b1001, 64'd3, 64'd0, s1, acc);
    issue(0, 4'b1111, 64'd9, 64'd9, s1, acc);
    idle();
    await_done(0, s, lat);
    chk("mulu.latency", 64'(lat), 64'd33);
    chk("mulu.result", 64'(b32.result), 64'h0000_0001);
    chk("mulu.result_hi", 64'(b32.result_hi), 64'hFFFF_FFFE);

    issue(0, 4'b1001, 64'd100, 64'd7, s, acc);
    await_done(0, s, lat);
    chk("divu.latency", 64'(lat), 64'd33);
    chk("divu.quot", 64'(b32.result), 64'd14);
    chk("divu.rem", 64'(b32.result_hi), 64'd2);

    issue(0, 4'b1001, 64'd9, 64'd0, s, acc);
    await_done(0, s, lat);
    chk("div0.latency", 64'(lat), 64'd1);
    chk("div0.result", 64'(b32.result), 64'hFFFF_FFFF);
    chk("div0.result_hi", 64'(b32.result_hi), 64'd9);
    chk("div0.flag", 64'(b32.div_zero), 64'd1);

    issue(0, 4'b1111, 64'd5, 64'd6, s, acc);
    await_done(0, s, lat);
    chk("illegal.latency", 64'(lat), 64'd1);
    chk("illegal.result", 64'(b32.result), 64'd0);
    chk("illegal.flag", 64'(b32.illegal), 64'd1);
    issue(0, 4'b0010, 64'd3, 64'd4, s, acc);
    await_done(0, s, lat);
    chk("add.result", 64'(b32.result), 64'd7);
    chk("add.illegal_clr", 64'(b32.illegal), 64'd0);

    // Start during the done cycle is dropped; the following cycle is taken.
    issue(0, 4'b0010, 64'd1, 64'd1, s, acc);
    issue(0, 4'b0001, 64'hF0, 64'h0F, s, acc);
    issue(0, 4'b0000, 64'hFF, 64'h0F, s, acc);
    await_done(0, s, lat);
    chk("b2b.latency", 64'(lat), 64'd1);
    chk("b2b.result", 64'(b32.result), 64'h0F);

    issue(1, 4'b1000, 64'd200, 64'd3, s, acc);
    await_done(1, s, lat);
    chk("w8.mulu.latency", 64'(lat), 64'd9);
    chk("w8.mulu.result", 64'(b8.result), 64'h58);
    chk("w8.mulu.result_hi", 64'(b8.result_hi), 64'h02);

    issue(0, 4'b1000, 64'h1234, 64'h5678, s, acc);
    repeat (5) idle();
    reset_n = 1'b0;
    clear_model();
    #1;
    chk("midrst.busy", 64'(b32.busy), 64'd0);
    chk("midrst.done", 64'(b32.done), 64'd0);
    chk("midrst.result", 64'(b32.result), 64'd0);
    chk("midrst.result_hi", 64'(b32.result_hi), 64'd0);
    chk("midrst.w8_result", 64'(b8.result), 64'd0);
    repeat (2) idle();
    reset_n = 1'b1;
    repeat (40) idle();

    random_run(1, 1000);
    random_run(0, 150);
    repeat (4) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
